tri_queue: RTL and testbench
============================

TRI_QUEUE -- requirements
Module: tri_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning triangle entries held (power of two, >=2).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 push  in  1  host write strobe; tri_in/color_in captured on the same clk edge.
REQ-005 tri_in  in  Triangle3D  host triangle (p, q, r Point3D).
REQ-006 color_in  in  Color  host fill colour (r, g, b, 8 bits each).
REQ-007 frame_start  in  1  host pulse: begin a frame.
REQ-008 frame_end  in  1  host pulse: no more triangles this frame.
REQ-009 full  out  1  count == DEPTH.
REQ-010 count  out  $clog2(DEPTH)+1  entries held.
REQ-011 overflow  out  1  sticky: push dropped while full.
REQ-012 triangle  out  Triangle3D  head entry to gpu; valid while tri_ready.
REQ-013 color  out  Color  head colour to gpu; valid while tri_ready.
REQ-014 tri_ready  out  1  offer head entry to gpu.
REQ-015 tri_read  in  1  gpu accepted offered entry.
REQ-016 cf_done  in  1  gpu colour fill of current triangle complete.
REQ-017 new_frame  out  1  one-cycle frame boundary pulse to gpu.
REQ-018 frame_done  out  1  one-cycle pulse: frame fully rendered.

Function
REQ-019 Storage SHALL be a circular FIFO, DEPTH entries of {Triangle3D, Color}, wrapping read/write pointers modulo DEPTH.
REQ-020 push with !full SHALL write tail and increment count in any state; push while full with no same-cycle pop SHALL drop data and set overflow.
REQ-021 push while full coinciding with a pop SHALL be accepted, count unchanged.
REQ-022 FSM states: IDLE, NEWF, WAIT, OFFER, BUSY, ENDF.
REQ-023 IDLE: frame_start -> NEWF; frame_end ignored.
REQ-024 NEWF: new_frame=1 for exactly one cycle -> WAIT.
REQ-025 WAIT: count>0 -> OFFER; else end_pending -> ENDF; else stay.
REQ-026 OFFER: tri_ready=1, triangle/color = head; tri_read sampled high -> pop head, -> BUSY.
REQ-027 BUSY: tri_ready=0; cf_done sampled high -> WAIT; tri_read ignored.
REQ-028 ENDF: new_frame=1 and frame_done=1 for one cycle, clear end_pending -> IDLE.
REQ-029 frame_end in any non-IDLE state SHALL set end_pending; frame_start outside IDLE SHALL be ignored.
REQ-030 Latency: push into empty queue at edge k while in WAIT SHALL give tri_ready=1 after edge k+1.
REQ-031 tri_ready SHALL deassert on the edge tri_read is sampled; at most one pop per offer.
REQ-032 triangle/color SHALL hold stable while tri_ready=1.
REQ-033 Pushed data before frame_start SHALL be retained and offered after NEWF.

Reset
REQ-034 rst SHALL force IDLE, pointers=0, count=0, full=0, overflow=0, end_pending=0, tri_ready=0, new_frame=0, frame_done=0, triangle/color=0.
REQ-035 rst mid-frame SHALL discard all queued entries and in-flight state with no further pulses.

Structure
REQ-036 Triangle3D, Point3D, Color, WIDTH, HEIGHT SHALL come from the shared defines package; FSM state enum local to tri_queue.
REQ-037 FIFO storage/pointers SHALL be one sub-module, tri_fifo; FSM in tri_queue.

Verification
REQ-038 frame_start, push 4 triangles (colours red, green, blue, white), gpu model pulses tri_read then cf_done 20 cycles later, frame_end -> one new_frame after start, 4 offers in push order, then new_frame+frame_done.
REQ-039 Push DEPTH+1 entries with no consumer -> full=1, count=8, overflow=1, 9th entry never offered.
REQ-040 Full queue, push coinciding with tri_read -> count stays 8, overflow=0, pushed entry offered last.
REQ-041 frame_start, frame_end with empty queue -> new_frame, then second new_frame with frame_done, no tri_ready.
REQ-042 rst asserted in BUSY with 3 queued -> all outputs 0, count=0; subsequent frame_start+1 push offers only the new entry.
REQ-043 cf_done pulse while OFFER and tri_read held low -> no pop, tri_ready stays 1, triangle unchanged.

Source files
------------

// File: rtl/tri_queue_pkg.sv
// Shared geometry and colour types for the triangle queue and the renderer it feeds.
package tri_queue_pkg;

    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int COORD_W = 16;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } Point3D;

    typedef struct packed {
        Point3D p;
        Point3D q;
        Point3D r;
    } Triangle3D;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } Color;

    typedef struct packed {
        Triangle3D geom;
        Color      fill;
    } queue_entry_t;

    function automatic queue_entry_t make_entry(input Triangle3D geom, input Color fill);
        queue_entry_t e;
        e.geom = geom;
        e.fill = fill;
        return e;
    endfunction

endpackage

// File: rtl/tri_queue_if.sv
// Host-side and gpu-side signals of the triangle queue; slave is the queue, master drives it.
interface tri_queue_if
    import tri_queue_pkg::*;
#(
    parameter int DEPTH = 8
);
    logic                     push;
    Triangle3D                tri_in;
    Color                     color_in;
    logic                     frame_start;
    logic                     frame_end;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    Triangle3D                triangle;
    Color                     color;
    logic                     tri_ready;
    logic                     tri_read;
    logic                     cf_done;
    logic                     new_frame;
    logic                     frame_done;

    modport master (
        output push, tri_in, color_in, frame_start, frame_end, tri_read, cf_done,
        input  full, count, overflow, triangle, color, tri_ready, new_frame, frame_done
    );

    modport slave (
        input  push, tri_in, color_in, frame_start, frame_end, tri_read, cf_done,
        output full, count, overflow, triangle, color, tri_ready, new_frame, frame_done
    );
endinterface

// File: rtl/tri_fifo.sv
// Circular triangle/colour store. A push into a full queue is taken only when a pop
// frees the head slot on the same edge; otherwise it is dropped and overflow latches.
module tri_fifo
    import tri_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  queue_entry_t           wr_data,
    input  logic                   pop,
    output queue_entry_t           rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    queue_entry_t  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [AW:0]   count_next_s;
    logic          full_r;
    logic          overflow_r;
    logic          do_push_s;
    logic          do_pop_s;
    logic          drop_s;

    // Accept/drop decision and next occupancy.
    always_comb begin
        do_pop_s  = pop && (count_r != CNT_ZERO);
        do_push_s = push && (!full_r || do_pop_s);
        drop_s    = push && full_r && !do_pop_s;
        if (do_push_s && !do_pop_s) begin
            count_next_s = count_r + CNT_ONE;
        end else if (do_pop_s && !do_push_s) begin
            count_next_s = count_r - CNT_ONE;
        end else begin
            count_next_s = count_r;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= CNT_ZERO;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            count_r    <= count_next_s;
            full_r     <= (count_next_s == CNT_FULL);
            overflow_r <= overflow_r | drop_s;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data  = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = full_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/tri_queue.sv
// Triangle queue between host and gpu: buffers triangles and sequences frame start,
// one-at-a-time offers with colour-fill handshake, and frame completion.
module tri_queue
    import tri_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    tri_queue_if.slave  bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_NEWF  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_OFFER = 3'd3;
    localparam logic [2:0] ST_BUSY  = 3'd4;
    localparam logic [2:0] ST_ENDF  = 3'd5;

    logic [2:0]             state_r;
    logic [2:0]             state_next_s;
    logic                   end_pending_r;
    logic                   end_pending_next_s;
    logic                   pop_s;
    queue_entry_t           head_s;
    logic [$clog2(DEPTH):0] count_s;
    logic                   full_s;
    logic                   overflow_s;
    Triangle3D              triangle_r;
    Color                   color_r;
    logic                   tri_ready_r;
    logic                   new_frame_r;
    logic                   frame_done_r;

    tri_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (bus.push),
        .wr_data  (make_entry(bus.tri_in, bus.color_in)),
        .pop      (pop_s),
        .rd_data  (head_s),
        .count    (count_s),
        .full     (full_s),
        .overflow (overflow_s)
    );

    // Frame sequencing; queued entries are drained before a pending frame end is honoured.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        if (bus.frame_end && (state_r != ST_IDLE)) begin
            end_pending_next_s = 1'b1;
        end else begin
            end_pending_next_s = end_pending_r;
        end
        case (state_r)
            ST_IDLE: begin
                if (bus.frame_start) begin
                    state_next_s = ST_NEWF;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_NEWF: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (count_s != '0) begin
                    state_next_s = ST_OFFER;
                end else if (end_pending_r) begin
                    state_next_s = ST_ENDF;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_OFFER: begin
                if (bus.tri_read) begin
                    pop_s        = 1'b1;
                    state_next_s = ST_BUSY;
                end else begin
                    state_next_s = ST_OFFER;
                end
            end
            ST_BUSY: begin
                if (bus.cf_done) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_BUSY;
                end
            end
            ST_ENDF: begin
                state_next_s       = ST_IDLE;
                end_pending_next_s = 1'b0;
            end
            default: begin
                state_next_s       = ST_IDLE;
                end_pending_next_s = 1'b0;
            end
        endcase
    end

    // State plus registered gpu-facing outputs, decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            end_pending_r <= 1'b0;
            tri_ready_r   <= 1'b0;
            new_frame_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            triangle_r    <= '0;
            color_r       <= '0;
        end else begin
            state_r       <= state_next_s;
            end_pending_r <= end_pending_next_s;
            tri_ready_r   <= (state_next_s == ST_OFFER);
            new_frame_r   <= (state_next_s == ST_NEWF) || (state_next_s == ST_ENDF);
            frame_done_r  <= (state_next_s == ST_ENDF);
            // Head is latched on entry so the offer stays stable while it is pending.
            if ((state_next_s == ST_OFFER) && (state_r != ST_OFFER)) begin
                triangle_r <= head_s.geom;
                color_r    <= head_s.fill;
            end
        end
    end

    assign bus.full       = full_s;
    assign bus.count      = count_s;
    assign bus.overflow   = overflow_s;
    assign bus.triangle   = triangle_r;
    assign bus.color      = color_r;
    assign bus.tri_ready  = tri_ready_r;
    assign bus.new_frame  = new_frame_r;
    assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_tri_queue.sv
// Self-checking bench for tri_queue: scenario tasks plus randomized traffic against a queue model.
module tb_tri_queue;
    import tri_queue_pkg::*;

    localparam int DEPTH = 8;

    logic tb_clk = 1'b0;
    logic rst;
    always #5 tb_clk = ~tb_clk;

    tri_queue_if #(.DEPTH(DEPTH)) bus();

    tri_queue #(.DEPTH(DEPTH)) dut (
        .clk (tb_clk),
        .rst (rst),
        .bus (bus)
    );

    int           n_checks = 0;
    int           n_fail   = 0;
    queue_entry_t mq[$];
    logic         ovf_m;
    int           nf_cnt, fd_cnt, both_cnt, rdy_cycles;

    function automatic Point3D rand_point();
        Point3D pt;
        pt.x = 16'($urandom);
        pt.y = 16'($urandom);
        pt.z = 16'($urandom);
        return pt;
    endfunction

    function automatic Triangle3D rand_tri();
        Triangle3D t;
        t.p = rand_point();
        t.q = rand_point();
        t.r = rand_point();
        return t;
    endfunction

    function automatic Color rand_col();
        return Color'(24'($urandom));
    endfunction

    // One clock: drive inputs, advance the model, sample pulses at the falling edge.
    task automatic cycle(input logic p, input Triangle3D t, input Color c,
                         input logic rd, input logic cf, input logic fs, input logic fe);
        logic pop_this;
        logic full_before;
        queue_entry_t e;
        pop_this    = bus.tri_ready && rd;
        full_before = (mq.size() == DEPTH);
        bus.push = p; bus.tri_in = t; bus.color_in = c;
        bus.tri_read = rd; bus.cf_done = cf; bus.frame_start = fs; bus.frame_end = fe;
        if (pop_this && mq.size() > 0) void'(mq.pop_front());
        if (p) begin
            if (!full_before || pop_this) begin
                e.geom = t; e.fill = c;
                mq.push_back(e);
            end else begin
                ovf_m = 1'b1;
            end
        end
        @(posedge tb_clk);
        @(negedge tb_clk);
        bus.push = 1'b0; bus.tri_read = 1'b0; bus.cf_done = 1'b0;
        bus.frame_start = 1'b0; bus.frame_end = 1'b0;
        nf_cnt     += int'(bus.new_frame);
        fd_cnt     += int'(bus.frame_done);
        both_cnt   += int'(bus.new_frame && bus.frame_done);
        rdy_cycles += int'(bus.tri_ready);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push_one(input Triangle3D t, input Color c);
        cycle(1'b1, t, c, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // GPU behaviour: wait for an offer, accept it, signal fill done 'gap' cycles later.
    task automatic gpu_serve(input int gap, output logic got, output Triangle3D t, output Color c);
        got = 1'b0; t = '0; c = '0;
        for (int i = 0; i < 60; i++) begin
            if (bus.tri_ready) break;
            idle(1);
        end
        if (bus.tri_ready) begin
            got = 1'b1; t = bus.triangle; c = bus.color;
            cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
            idle(gap - 1);
            cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge tb_clk);
        rst = 1'b0;
        mq.delete();
        ovf_m = 1'b0;
        nf_cnt = 0; fd_cnt = 0; both_cnt = 0; rdy_cycles = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge tb_clk);
        n_checks++; if (bus.tri_ready !== 1'b0) begin n_fail++; $display("FAIL reset_tri_ready got %b want 0", bus.tri_ready); end
        n_checks++; if (bus.new_frame !== 1'b0) begin n_fail++; $display("FAIL reset_new_frame got %b want 0", bus.new_frame); end
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
        n_checks++; if (bus.count !== '0 || bus.full !== 1'b0 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_fifo count=%0d full=%b ovf=%b want 0/0/0", bus.count, bus.full, bus.overflow); end
        n_checks++; if (bus.triangle !== '0 || bus.color !== '0) begin
            n_fail++; $display("FAIL reset_data tri=%h col=%h want 0", bus.triangle, bus.color); end
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        n_checks++; if (nf_cnt !== 0 || fd_cnt !== 0) begin
            n_fail++; $display("FAIL idle_frame_end nf=%0d fd=%0d want 0/0", nf_cnt, fd_cnt); end
    endtask

    task automatic test_frame_basic();
        Color cols[4];
        queue_entry_t exp;
        logic got; Triangle3D t; Color c;
        cols[0] = Color'(24'hFF0000); cols[1] = Color'(24'h00FF00);
        cols[2] = Color'(24'h0000FF); cols[3] = Color'(24'hFFFFFF);
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (nf_cnt !== 1) begin n_fail++; $display("FAIL basic_new_frame got %0d want 1", nf_cnt); end
        for (int i = 0; i < 4; i++) push_one(rand_tri(), cols[i]);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp = mq[0];
            gpu_serve(20, got, t, c);
            n_checks++; if (got !== 1'b1 || t !== exp.geom || c !== cols[i]) begin
                n_fail++; $display("FAIL basic_offer%0d got=%b tri=%h col=%h want tri=%h col=%h", i, got, t, c, exp.geom, cols[i]); end
        end
        n_checks++; if (nf_cnt !== 1 || fd_cnt !== 0) begin
            n_fail++; $display("FAIL basic_early_end nf=%0d fd=%0d want 1/0", nf_cnt, fd_cnt); end
        idle(6);
        n_checks++; if (nf_cnt !== 2 || fd_cnt !== 1 || both_cnt !== 1) begin
            n_fail++; $display("FAIL basic_frame_done nf=%0d fd=%0d both=%0d want 2/1/1", nf_cnt, fd_cnt, both_cnt); end
    endtask

    task automatic test_overflow();
        queue_entry_t exp;
        logic got; Triangle3D t; Color c;
        int rdy_before;
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) begin
            push_one(rand_tri(), rand_col());
            if (i == DEPTH - 2) begin
                n_checks++; if (bus.full !== 1'b0) begin n_fail++; $display("FAIL ovf_full_early got %b want 0 at count %0d", bus.full, bus.count); end
            end
        end
        n_checks++; if (bus.full !== 1'b1 || int'(bus.count) !== DEPTH || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_state full=%b count=%0d ovf=%b want 1/%0d/1", bus.full, bus.count, bus.overflow, DEPTH); end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            exp = mq[0];
            gpu_serve(2, got, t, c);
            n_checks++; if (got !== 1'b1 || t !== exp.geom || c !== exp.fill) begin
                n_fail++; $display("FAIL ovf_offer%0d got=%b tri=%h want %h", i, got, t, exp.geom); end
        end
        rdy_before = rdy_cycles;
        idle(10);
        n_checks++; if (rdy_cycles !== rdy_before || bus.count !== '0 || bus.overflow !== 1'b1) begin
            n_fail++; $display("FAIL ovf_ninth rdy=%0d count=%0d ovf=%b want no offer/0/1", rdy_cycles - rdy_before, bus.count, bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        queue_entry_t exp;
        logic got; Triangle3D t; Color c; Triangle3D last_t;
        do_reset();
        for (int i = 0; i < DEPTH; i++) push_one(rand_tri(), rand_col());
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            if (bus.tri_ready) break;
            idle(1);
        end
        last_t = rand_tri();
        cycle(1'b1, last_t, rand_col(), 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (int'(bus.count) !== DEPTH || bus.full !== 1'b1 || bus.overflow !== 1'b0) begin
            n_fail++; $display("FAIL fpp_state count=%0d full=%b ovf=%b want %0d/1/0", bus.count, bus.full, bus.overflow, DEPTH); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            exp = mq[0];
            gpu_serve(2, got, t, c);
            n_checks++; if (got !== 1'b1 || t !== exp.geom || c !== exp.fill) begin
                n_fail++; $display("FAIL fpp_offer%0d got=%b tri=%h want %h", i, got, t, exp.geom); end
        end
        n_checks++; if (t !== last_t) begin n_fail++; $display("FAIL fpp_last tri=%h want %h", t, last_t); end
    endtask

    task automatic test_empty_frame();
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        n_checks++; if (nf_cnt !== 2 || fd_cnt !== 1 || both_cnt !== 1 || rdy_cycles !== 0) begin
            n_fail++; $display("FAIL empty_frame nf=%0d fd=%0d both=%0d rdy=%0d want 2/1/1/0", nf_cnt, fd_cnt, both_cnt, rdy_cycles); end
    endtask

    task automatic test_reset_mid();
        logic got; Triangle3D t; Color c; Triangle3D new_t;
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) push_one(rand_tri(), rand_col());
        for (int i = 0; i < 20; i++) begin
            if (bus.tri_ready) break;
            idle(1);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        n_checks++; if (int'(bus.count) !== 3 || bus.tri_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_busy count=%0d rdy=%b want 3/0", bus.count, bus.tri_ready); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (bus.tri_ready !== 1'b0 || bus.new_frame !== 1'b0 || bus.frame_done !== 1'b0 ||
                        bus.count !== '0 || bus.full !== 1'b0 || bus.overflow !== 1'b0 ||
                        bus.triangle !== '0 || bus.color !== '0) begin
            n_fail++; $display("FAIL mid_reset rdy=%b nf=%b fd=%b count=%0d tri=%h want all 0",
                               bus.tri_ready, bus.new_frame, bus.frame_done, bus.count, bus.triangle); end
        @(negedge tb_clk);
        rst = 1'b0;
        mq.delete(); ovf_m = 1'b0;
        nf_cnt = 0; fd_cnt = 0; both_cnt = 0; rdy_cycles = 0;
        idle(3);
        n_checks++; if (nf_cnt !== 0 || rdy_cycles !== 0) begin
            n_fail++; $display("FAIL mid_no_pulse nf=%0d rdy=%0d want 0/0", nf_cnt, rdy_cycles); end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        new_t = rand_tri();
        push_one(new_t, rand_col());
        gpu_serve(3, got, t, c);
        n_checks++; if (got !== 1'b1 || t !== new_t) begin
            n_fail++; $display("FAIL mid_new_entry got=%b tri=%h want %h", got, t, new_t); end
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(6);
        n_checks++; if (fd_cnt !== 1 || bus.count !== '0 || bus.tri_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_only_one fd=%0d count=%0d rdy=%b want 1/0/0", fd_cnt, bus.count, bus.tri_ready); end
    endtask

    task automatic test_latency_cf_in_offer();
        Triangle3D t1;
        logic got; Triangle3D t; Color c;
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        t1 = rand_tri();
        push_one(t1, rand_col());
        n_checks++; if (bus.tri_ready !== 1'b0) begin n_fail++; $display("FAIL lat_edge_k rdy=%b want 0", bus.tri_ready); end
        idle(1);
        n_checks++; if (bus.tri_ready !== 1'b1 || bus.triangle !== t1) begin
            n_fail++; $display("FAIL lat_edge_k1 rdy=%b tri=%h want 1/%h", bus.tri_ready, bus.triangle, t1); end
        cycle(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        n_checks++; if (bus.tri_ready !== 1'b1 || bus.triangle !== t1 || int'(bus.count) !== 1) begin
            n_fail++; $display("FAIL cf_in_offer rdy=%b tri=%h count=%0d want 1/%h/1", bus.tri_ready, bus.triangle, bus.count, t1); end
        gpu_serve(2, got, t, c);
        n_checks++; if (got !== 1'b1 || bus.count !== '0) begin
            n_fail++; $display("FAIL cf_cleanup got=%b count=%0d want 1/0", got, bus.count); end
    endtask

    task automatic test_random();
        logic p, rd, cf;
        do_reset();
        cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            p  = ($urandom_range(0, 2) != 0);
            rd = ($urandom_range(0, 1) != 0);
            cf = ($urandom_range(0, 3) == 0);
            cycle(p, rand_tri(), rand_col(), rd, cf, 1'b0, 1'b0);
            n_checks++; if (int'(bus.count) !== mq.size() || bus.full !== (mq.size() == DEPTH) || bus.overflow !== ovf_m) begin
                n_fail++; $display("FAIL rnd_state cyc=%0d count=%0d full=%b ovf=%b want %0d/%b/%b",
                                   i, bus.count, bus.full, bus.overflow, mq.size(), mq.size() == DEPTH, ovf_m); end
            if (bus.tri_ready) begin
                n_checks++;
                if (mq.size() == 0) begin
                    n_fail++; $display("FAIL rnd_offer_empty cyc=%0d rdy=1 want no offer", i);
                end else if (bus.triangle !== mq[0].geom || bus.color !== mq[0].fill) begin
                    n_fail++; $display("FAIL rnd_offer cyc=%0d tri=%h want %h", i, bus.triangle, mq[0].geom);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.push = 1'b0; bus.tri_in = '0; bus.color_in = '0;
        bus.frame_start = 1'b0; bus.frame_end = 1'b0;
        bus.tri_read = 1'b0; bus.cf_done = 1'b0;
        ovf_m = 1'b0;
        nf_cnt = 0; fd_cnt = 0; both_cnt = 0; rdy_cycles = 0;
        test_reset();
        test_frame_basic();
        test_overflow();
        test_full_push_pop();
        test_empty_frame();
        test_reset_mid();
        test_latency_cf_in_offer();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
